// File: rtl/wb_sram_slave.sv
// Wishbone classic responder backed by a word-addressed 32-bit SRAM.
// It inserts a configurable number of wait states and returns an error for out-of-range addresses.
module wb_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            wait_cnt_reg, wait_cnt_next;
  logic                  err_reg;
  logic [31:0]           dat_reg;
  logic                  req;
  logic                  in_range;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            lane_we;
  logic                  unused_adr;
  logic [31:0]           mem [DEPTH];

  assign req        = wb_cyc_i & wb_stb_i;
  assign word_idx   = wb_adr_i[ADDR_WIDTH+1:2];
  assign in_range   = (wb_adr_i >> (ADDR_WIDTH + 2)) == 32'd0;
  assign unused_adr = ^wb_adr_i[1:0];

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    commit        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_next = S_RESP;
            commit     = 1'b1;
          end else begin
            state_next    = S_WAIT;
            wait_cnt_next = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Dropping the request while waiting abandons the access entirely.
        if (!req) begin
          state_next    = S_IDLE;
          wait_cnt_next = 4'd0;
        end else if (wait_cnt_reg == 4'd0) begin
          state_next = S_RESP;
          commit     = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next    = S_IDLE;
        wait_cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      err_reg      <= 1'b0;
      dat_reg      <= 32'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (commit) begin
        err_reg <= ~in_range;
        if (!in_range) begin
          dat_reg <= 32'd0;
        end else if (!wb_we_i) begin
          dat_reg <= mem[word_idx];
        end
      end
    end
  end

  // Per-lane write enables; a reset on the commit edge suppresses the write.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = commit & ~rst & wb_we_i & in_range & wb_sel_i[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) begin
        mem[word_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  assign wb_ack_o = (state_reg == S_RESP) & ~err_reg;
  assign wb_err_o = (state_reg == S_RESP) &  err_reg;
  assign wb_dat_o = dat_reg;

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
Wishbone classic single-cycle responder (slave) backed by a 32-bit word-addressed SRAM array. It is the target end of the bus our CPU's Wishbone bus interface initiates on, and it replaces the flat instruction/data memory models in the SOPC. Configurable wait states allow exercising the CPU's stall path. Out-of-range accesses are flagged with an error response.

Parameters:
ADDR_WIDTH, 10, word-address bits; array depth is 2^ADDR_WIDTH words of 32 bits.
WAIT_STATES, 2, cycles inserted between request acceptance and the response; legal range 0..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high (rst=1 sampled at a rising edge resets the block).
wb_cyc_i  input  1  bus cycle valid.
wb_stb_i  input  1  strobe; request valid when wb_cyc_i & wb_stb_i.
wb_we_i  input  1  1 = write, 0 = read.
wb_adr_i  input  32  byte address; bits [1:0] ignored.
wb_sel_i  input  4  byte lane enables; bit n selects data[8n+7:8n].
wb_dat_i  input  32  write data.
wb_dat_o  output  32  read data, valid while wb_ack_o=1 and held until the next completed read.
wb_ack_o  output  1  normal termination, one-cycle pulse.
wb_err_o  output  1  error termination (out-of-range address), one-cycle pulse.

Behaviour:
- Reset: state=IDLE, wait counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0. Array contents are not reset. rst has priority over every other event.
- Request: req = wb_cyc_i & wb_stb_i. Word index = wb_adr_i[ADDR_WIDTH+1:2].
- In range: wb_adr_i[31:ADDR_WIDTH+2] == 0. Otherwise the access is out of range.
- FSM states:
  - IDLE: if req, go to WAIT with counter=WAIT_STATES-1 when WAIT_STATES>0; go directly to RESP when WAIT_STATES=0. Otherwise stay in IDLE.
  - WAIT: if req drops, go to IDLE. This is an abort: no write, no ack, no err. Else if counter==0, go to RESP. Else decrement the counter.
  - RESP: assert exactly one of wb_ack_o/wb_err_o for this single cycle, then go unconditionally to IDLE.
- Commit edge: the rising edge that enters RESP, using live bus inputs. The master holds them stable per Wishbone.
  - In-range write: array[idx] byte n <= wb_dat_i byte n for each wb_sel_i[n]=1; other bytes are unchanged. wb_dat_o is unchanged.
  - In-range read: wb_dat_o <= array[idx]; wb_sel_i is ignored and the full word is returned.
  - Out of range: no array update; wb_dat_o <= 0; err is raised instead of ack.
  - wb_sel_i=0000 on a write: legal; ack is asserted and memory is unchanged.
- Latency: the response is asserted WAIT_STATES+1 cycles after the first cycle req is high in IDLE.
- Minimum spacing: one transfer every WAIT_STATES+2 cycles, because IDLE is always visited after RESP.
- Back-to-back: req still high in the cycle after RESP is treated as a new transaction starting from IDLE.
- wb_ack_o and wb_err_o are never high together, and never high outside RESP.
- Reset mid-transaction: a transaction in WAIT is dropped with no write. If rst is sampled on the would-be commit edge, no write occurs and no response is asserted next cycle.
- Reads and writes to the same word in consecutive transactions return the newly written data. No forwarding issue arises, since commits are sequential.

Test Plan:
- Reset: hold rst=1 for 3 cycles while req=1 -> ack/err/dat_o stay 0 throughout. After release with req=0, the block stays idle.
- Write then read, WAIT_STATES=2: write adr=0x0000_0010, sel=1111, dat=0xDEADBEEF -> ack exactly 3 cycles after req, for 1 cycle. Then read the same address -> ack after 3 cycles with dat_o=0xDEADBEEF, and dat_o holds afterward.
- Byte lanes: word 0x10 holds 0xDEADBEEF; write sel=0101, dat=0x11223344 -> a subsequent read returns 0xDE22BE44.
- Abort: start a read at 0x20 and drop stb after 1 cycle of WAIT -> no ack or err ever appears. A following write to 0x20 completes normally with latency 3.
- Out of range, ADDR_WIDTH=10: write to 0x0000_1000 -> err pulses once with no ack, and a read at 0x0 is unaffected. A read at 0x0000_1000 -> err with dat_o=0.
- WAIT_STATES=0 with req held high continuously -> ack pattern 0,1,0,1,... (one transfer per 2 cycles), each ack carrying correct read data. Assert rst on a commit edge -> no ack next cycle and memory is unchanged.
